// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and round-robin helper for the sync FIFO write-side logic.
// Optional packet lock is enabled with SYNC_FIFO_ARB_LOCK_EN (see sync_fifo_wr_arbiter).
package sync_fifo_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned RR_MAX_REQ     = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Reference round-robin pick: first valid index at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [3:0]            ptr,
                                         input int unsigned           n);
        rr_pick_t r;
        int unsigned j;
        r = '0;
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (k < int'(n)) begin
                j = (int'(ptr) + k) % n;
                if (valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = 4'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: masked/unmasked double priority encode from ptr.
// Reusable by any scheduler that needs a rotating-priority one-of-N choice.
module rr_priority_picker #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  masked;
    logic          m_found;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;

    always_comb begin
        masked  = '0;
        m_found = 1'b0;
        m_idx   = '0;
        found   = 1'b0;
        u_idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked[i] = valid[i] && (i >= int'(ptr));
        end
        // Walk downward so the lowest set index is the one left standing.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                m_found = 1'b1;
                m_idx   = IW'(i);
            end
            if (valid[i]) begin
                found = 1'b1;
                u_idx = IW'(i);
            end
        end
        idx = m_found ? m_idx : u_idx;
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Define SYNC_FIFO_ARB_LOCK_EN to hold the grant on one producer until its req_last beat.
module sync_fifo_wr_arbiter
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [SRC_W-1:0]              fifo_src,
    output logic                          busy
);

    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [SRC_W-1:0]      src_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [SRC_W-1:0]      pick_idx, win;
    logic                  pick_found, win_found, accept;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .valid (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef SYNC_FIFO_ARB_LOCK_EN
    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;

    always_comb begin
        win       = pick_idx;
        win_found = pick_found;
        if (state_q == ARB_LOCKED) begin
            win       = owner_q;
            win_found = req_valid[owner_q];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (accept) begin
            if (state_q == ARB_IDLE && !req_last[win]) begin
                state_d = ARB_LOCKED;
                owner_d = win;
            end else if (state_q == ARB_LOCKED && req_last[win]) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign busy = (state_q == ARB_LOCKED);
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign win         = pick_idx;
    assign win_found   = pick_found;
    assign busy        = 1'b0;
`endif

    assign accept = win_found && !fifo_full;

    always_comb begin
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == SRC_W'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (accept) req_ready[win] = 1'b1;
        fifo_wr_en = accept;
        // Idle cycles replay the last written beat so downstream never sees X.
        fifo_din   = accept ? sel_data : din_q;
        fifo_src   = accept ? win : src_q;
        ptr_d      = ptr_q;
        if (accept) ptr_d = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            src_q <= '0;
            din_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            src_q <= fifo_src;
            din_q <= fifo_din;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic on a 4-way and a 3-way arbiter.
// Lock-mode expectations are compiled in when SYNC_FIFO_ARB_LOCK_EN is defined.
module tb_sync_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int N3  = 3;
    localparam int DW3 = 16;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    logic [N-1:0]    v4, l4, rdy4;
    logic [N*DW-1:0] d4;
    logic            f4, we4, busy4;
    logic [DW-1:0]   din4;
    logic [1:0]      src4;

    logic [N3-1:0]     v3, l3, rdy3;
    logic [N3*DW3-1:0] d3;
    logic              f3, we3, busy3;
    logic [DW3-1:0]    din3;
    logic [1:0]        src3;

    always #5 clock = ~clock;

    sync_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) u_dut (
        .clock(clock), .rst(rst), .req_valid(v4), .req_data(d4), .req_last(l4),
        .req_ready(rdy4), .fifo_full(f4), .fifo_wr_en(we4), .fifo_din(din4),
        .fifo_src(src4), .busy(busy4)
    );

    sync_fifo_wr_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW3)) u_dut3 (
        .clock(clock), .rst(rst), .req_valid(v3), .req_data(d3), .req_last(l3),
        .req_ready(rdy3), .fifo_full(f3), .fifo_wr_en(we3), .fifo_din(din3),
        .fifo_src(src3), .busy(busy3)
    );

    // Reference model state, one slot per DUT: 0 = 4-way, 1 = 3-way.
    int          m_ptr[2];
    int          m_owner[2];
    bit          m_lock[2];
    int          m_src[2];
    logic [63:0] m_din[2];
    int          e_win[2];
    bit          e_acc[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input int k, input int i);
        if (k == 0) return d4[i*DW +: DW];
        return 64'(d3[i*DW3 +: DW3]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_owner[k] = 0; m_lock[k] = 0;
            m_src[k] = 0; m_din[k] = '0; e_acc[k] = 0; e_win[k] = 0;
        end
    endtask

    task automatic model_check(input int k);
        int          n, win, exp_src;
        bit          found, full;
        logic [15:0] v, exp_rdy, act_rdy;
        logic [63:0] exp_din;
        n = (k == 0) ? N : N3;
        v = (k == 0) ? 16'(v4) : 16'(v3);
        full = (k == 0) ? f4 : f3;
        found = 0;
        win = 0;
        if (m_lock[k]) begin
            found = v[m_owner[k]];
            win   = m_owner[k];
        end else begin
            for (int j = 0; j < n; j++) begin
                if (!found && v[(m_ptr[k] + j) % n]) begin
                    found = 1;
                    win   = (m_ptr[k] + j) % n;
                end
            end
        end
        e_acc[k] = found && !full;
        e_win[k] = win;
        exp_rdy  = e_acc[k] ? (16'(1) << win) : 16'h0;
        exp_src  = e_acc[k] ? win : m_src[k];
        exp_din  = e_acc[k] ? data_of(k, win) : m_din[k];
        act_rdy  = (k == 0) ? 16'(rdy4) : 16'(rdy3);
        chk($sformatf("d%0d ready", k), 64'(act_rdy), 64'(exp_rdy));
        chk($sformatf("d%0d wr_en", k), 64'((k == 0) ? we4 : we3), 64'(e_acc[k]));
        chk($sformatf("d%0d src", k), 64'((k == 0) ? src4 : src3), 64'(exp_src));
        chk($sformatf("d%0d din", k), (k == 0) ? din4 : 64'(din3), exp_din);
        chk($sformatf("d%0d busy", k), 64'((k == 0) ? busy4 : busy3), 64'(m_lock[k]));
    endtask

    task automatic model_update(input int k);
        int n;
`ifdef SYNC_FIFO_ARB_LOCK_EN
        logic [15:0] l;
        l = (k == 0) ? 16'(l4) : 16'(l3);
`endif
        n = (k == 0) ? N : N3;
        if (!e_acc[k]) return;
        m_ptr[k] = (e_win[k] + 1) % n;
        m_src[k] = e_win[k];
        m_din[k] = data_of(k, e_win[k]);
`ifdef SYNC_FIFO_ARB_LOCK_EN
        if (!m_lock[k] && !l[e_win[k]]) begin
            m_lock[k]  = 1;
            m_owner[k] = e_win[k];
        end else if (m_lock[k] && l[e_win[k]]) begin
            m_lock[k] = 0;
        end
`endif
    endtask

    // Caller drives inputs after a negedge and waits #1; this checks, clocks, and returns at the next negedge.
    task automatic step();
        model_check(0);
        model_check(1);
        @(posedge clock);
        if (rst) begin
            model_update(0);
            model_update(1);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic rand_req(input int k);
        int n;
        n = (k == 0) ? N : N3;
        for (int i = 0; i < n; i++) begin
            bit hold;
            hold = (k == 0) ? v4[i] : v3[i];
            hold = hold && !(e_acc[k] && e_win[k] == i);
            if (!hold) begin
                if (k == 0) begin
                    v4[i] = ($urandom % 2) == 0;
                    l4[i] = ($urandom % 3) == 0;
                    d4[i*DW +: DW] = {$urandom, $urandom};
                end else begin
                    v3[i] = ($urandom % 2) == 0;
                    l3[i] = ($urandom % 3) == 0;
                    d3[i*DW3 +: DW3] = 16'($urandom);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        v4 = '0; l4 = '0; d4 = '0; f4 = 1'b0;
        v3 = '0; l3 = '0; d3 = '0; f3 = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("reset din", din4, 64'h0);
        chk("reset src", 64'(src4), 64'h0);
        chk("reset busy", 64'(busy4), 64'h0);
        chk("reset wr_en", 64'(we4), 64'h0);
        chk("reset din3", 64'(din3), 64'h0);
        @(negedge clock);
        rst = 1'b1;

        // Basic write: only req 2 valid
        v4 = 4'b0100;
        d4[2*DW +: DW] = 64'hA5;
        #1;
        chk("basic ready", 64'(rdy4), 64'h4);
        chk("basic wr_en", 64'(we4), 64'h1);
        chk("basic din", din4, 64'hA5);
        chk("basic src", 64'(src4), 64'h2);
        step();
        v4 = 4'b1111;
        for (int i = 0; i < N; i++) d4[i*DW +: DW] = {$urandom, $urandom};
        #1;
        chk("basic ptr3", 64'(src4), 64'h3);
        step();

        // Fairness from ptr 0
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("fair src c%0d", c), 64'(src4), 64'(c % N));
            step();
        end

        // Full backpressure after the src 1 grant
        #1; chk("bp src0", 64'(src4), 64'h0); step();
        #1; chk("bp src1", 64'(src4), 64'h1); step();
        f4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp ready", 64'(rdy4), 64'h0);
            chk("bp wr_en", 64'(we4), 64'h0);
            chk("bp src hold", 64'(src4), 64'h1);
            step();
        end
        f4 = 1'b0;
        #1; chk("bp resume", 64'(src4), 64'h2); step();
        v4 = '0;

        // 3-way wrap: move ptr to 2, then reqs 2 and 0
        v3 = 3'b010;
        #1; chk("wrap src1", 64'(src3), 64'h1); step();
        v3 = 3'b101;
        #1; chk("wrap src2", 64'(src3), 64'h2); step();
        #1; chk("wrap src0", 64'(src3), 64'h0); step();
        #1; chk("wrap ptr1", 64'(src3), 64'h2); step();
        v3 = '0;

        // Packet lock on req 1 with reqs 0 and 3 competing
        do_reset();
        v4 = 4'b0001; l4 = 4'b0001;
        #1; step();
        v4 = 4'b1011; l4 = 4'b0000;
        #1; chk("lock b1 src", 64'(src4), 64'h1); step();
`ifdef SYNC_FIFO_ARB_LOCK_EN
        #1;
        chk("lock b2 src", 64'(src4), 64'h1);
        chk("lock b2 busy", 64'(busy4), 64'h1);
        step();
        v4 = 4'b1001;
        #1;
        chk("lock gap wr_en", 64'(we4), 64'h0);
        chk("lock gap busy", 64'(busy4), 64'h1);
        step();
        v4 = 4'b1011; l4 = 4'b0010;
        #1;
        chk("lock b3 src", 64'(src4), 64'h1);
        chk("lock b3 busy", 64'(busy4), 64'h1);
        step();
        v4 = 4'b1001; l4 = 4'b0000;
        #1;
        chk("lock after src", 64'(src4), 64'h3);
        chk("lock after busy", 64'(busy4), 64'h0);
        step();
`else
        #1; step();
        v4 = 4'b1001;
        #1; step();
`endif

        // Asynchronous reset between beats of a packet
        v4 = 4'b1111; l4 = 4'b0000;
        #1; step();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("arst busy", 64'(busy4), 64'h0);
        chk("arst src", 64'(src4), 64'h0);
        model_check(0);
        @(negedge clock);
        rst = 1'b1;
        #1; chk("arst first", 64'(src4), 64'h0); step();

        // Randomized traffic on both arbiters
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_req(0);
            rand_req(1);
            f4 = ($urandom % 4) == 0;
            f3 = ($urandom % 4) == 0;
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
